// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg -- shared constants and types for the pipeline hazard controller.
//   Opcode/aluop encodings, FSM state encoding, default mult/div timeout,
//   and the latch-control bundle used to build the hazard_ctrl outputs.
package hazard_ctrl_pkg;

    // Instruction encodings
    localparam logic [4:0] OP_ALU    = 5'b00000;
    localparam logic [4:0] OP_LW     = 5'b01000;
    localparam logic [4:0] ALUOP_MUL = 5'b00110;
    localparam logic [4:0] ALUOP_DIV = 5'b00111;

    // Default number of MD_WAIT cycles before a forced release
    localparam int MD_TIMEOUT_DEF = 40;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_t;

    // Pipeline latch controls driven by the hazard unit
    typedef struct packed {
        logic pc_en;
        logic fd_en;
        logic dx_en;
        logic xm_en;
        logic mw_en;
        logic fd_flush;
        logic dx_flush;
        logic xm_flush;
    } latch_ctl_t;

    // Free-running pipeline: everything advances, nothing is squashed
    localparam latch_ctl_t CTL_NORMAL = '{
        pc_en: 1'b1, fd_en: 1'b1, dx_en: 1'b1, xm_en: 1'b1, mw_en: 1'b1,
        fd_flush: 1'b0, dx_flush: 1'b0, xm_flush: 1'b0
    };

    // Mult/div in flight: front end frozen, bubbles fed into X/M
    localparam latch_ctl_t CTL_MD_HOLD = '{
        pc_en: 1'b0, fd_en: 1'b0, dx_en: 1'b0, xm_en: 1'b1, mw_en: 1'b1,
        fd_flush: 1'b0, dx_flush: 1'b0, xm_flush: 1'b1
    };

    // True when the D/X instruction is a multiply or divide
    function automatic logic is_mult_div(input logic [4:0] opcode,
                                         input logic [4:0] aluop);
        return (opcode == OP_ALU) && ((aluop == ALUOP_MUL) || (aluop == ALUOP_DIV));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// satCounter16 -- 16-bit saturating up-counter.
//   clock  : rising-edge clock
//   clear  : synchronous clear to zero (has priority over enable)
//   enable : count up by one this cycle
//   count  : current value, holds at 16'hFFFF once reached
module satCounter16 (
    input  logic        clock,
    input  logic        clear,
    input  logic        enable,
    output logic [15:0] count
);

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (enable && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- stall/flush controller for a 5-stage pipeline.
//   Handles taken-branch squash, load-use one-bubble stall, and freezing the
//   front end while the multdiv unit is busy (with a timeout release).
// Ports:
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   dxOpcode, dxAluop, dxRd      : instruction currently in the D/X latch
//   fdRs, fdRt, fdUsesRt         : source operands of the F/D instruction
//   branchTaken                  : X stage resolved a taken branch/jump
//   mdResultReady                : multdiv result valid
//   pc/fd/dx/xm/mwEnable         : latch write enables
//   fd/dx/xmFlush                : force latch next value to nop
//   mdStart                      : one-cycle multdiv start
//   mdTimeout                    : one-cycle pulse on forced release
//   stallCount                   : saturating count of cycles with pcEnable=0
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int         MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter logic [4:0] LW_OPCODE  = OP_LW
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  dxOpcode,
    input  logic [4:0]  dxAluop,
    input  logic [4:0]  dxRd,
    input  logic [4:0]  fdRs,
    input  logic [4:0]  fdRt,
    input  logic        fdUsesRt,
    input  logic        branchTaken,
    input  logic        mdResultReady,
    output logic        pcEnable,
    output logic        fdEnable,
    output logic        dxEnable,
    output logic        xmEnable,
    output logic        mwEnable,
    output logic        fdFlush,
    output logic        dxFlush,
    output logic        xmFlush,
    output logic        mdStart,
    output logic        mdTimeout,
    output logic [15:0] stallCount
);

    localparam int               CNT_W    = $clog2(MD_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    latch_ctl_t       ctl;
    logic             md_hit;
    logic             load_use;
    logic             md_start;
    logic             md_expire;

    // Hazard detection on the D/X and F/D contents
    assign md_hit   = is_mult_div(dxOpcode, dxAluop);
    assign load_use = (dxOpcode == LW_OPCODE) && (dxRd != 5'd0) &&
                      ((dxRd == fdRs) || (fdUsesRt && (dxRd == fdRt)));

    // Latch controls are combinational so a hazard is answered in the cycle
    // it is seen; reset forces the free-running pattern.
    always_comb begin
        ctl       = CTL_NORMAL;
        md_start  = 1'b0;
        md_expire = 1'b0;
        if (!reset) begin
            case (state)
                ST_RUN: begin
                    if (branchTaken) begin
                        // Squash the two younger instructions; the branch itself
                        // still advances into X/M.
                        ctl.fd_flush = 1'b1;
                        ctl.dx_flush = 1'b1;
                    end else if (md_hit) begin
                        ctl      = CTL_MD_HOLD;
                        md_start = 1'b1;
                    end else if (load_use) begin
                        ctl.pc_en    = 1'b0;
                        ctl.fd_en    = 1'b0;
                        ctl.dx_flush = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    // branchTaken is deliberately ignored here: the mult/div is
                    // still in D/X, so no branch can be resolving in X.
                    if (mdResultReady) begin
                        ctl = CTL_NORMAL;
                    end else if (wait_cnt == CNT_LAST) begin
                        ctl       = CTL_NORMAL;
                        md_expire = 1'b1;
                    end else begin
                        ctl = CTL_MD_HOLD;
                    end
                end
                default: ctl = CTL_NORMAL;
            endcase
        end
    end

    // FSM and wait counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!branchTaken && md_hit) begin
                        state    <= ST_MD_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_MD_WAIT: begin
                    if (mdResultReady || (wait_cnt == CNT_LAST)) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign pcEnable  = ctl.pc_en;
    assign fdEnable  = ctl.fd_en;
    assign dxEnable  = ctl.dx_en;
    assign xmEnable  = ctl.xm_en;
    assign mwEnable  = ctl.mw_en;
    assign fdFlush   = ctl.fd_flush;
    assign dxFlush   = ctl.dx_flush;
    assign xmFlush   = ctl.xm_flush;
    assign mdStart   = md_start;
    assign mdTimeout = md_expire;

    satCounter16 u_stall_cnt (
        .clock  (clock),
        .clear  (reset),
        .enable (!ctl.pc_en),
        .count  (stallCount)
    );

endmodule
